// File: rtl/mem_arb.sv
// Memory arbiter: one memory port shared by a fetch and a data requester.
// One transaction in flight; data has priority but never starves fetch.
module mem_arb #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_done,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    input  logic        m_rvalid,
    input  logic [31:0] m_rdata,
    output logic        stall,
    output logic        err
);

    localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    typedef enum logic {OWN_IF, OWN_D} owner_t;

    state_t        state;
    owner_t        owner;
    logic          last_d;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic          tmo;
    logic          done_any;
    logic          grant_d;
    logic          grant_if;
    logic          abort;

    assign cnt_inc  = cnt + 1'b1;
    assign tmo      = (cnt_inc == TMO);
    assign done_any = if_done | d_done;

    // No grant in a done cycle: the finished requester still holds req.
    assign grant_d  = ~done_any & d_req & ~(last_d & if_req);
    assign grant_if = ~done_any & if_req & ~grant_d;

    // A response arriving on the last allowed cycle still completes.
    assign abort = tmo & ((state == REQ) | ((state == WAIT) & ~m_rvalid));

    assign stall = (if_req & ~if_done) | (d_req & ~d_done);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            owner    <= OWN_IF;
            last_d   <= 1'b0;
            cnt      <= '0;
            m_valid  <= 1'b0;
            m_we     <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            m_wstrb  <= '0;
            if_done  <= 1'b0;
            d_done   <= 1'b0;
            if_rdata <= '0;
            d_rdata  <= '0;
            err      <= 1'b0;
        end else begin
            if_done <= 1'b0;
            d_done  <= 1'b0;
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (grant_d) begin
                        owner   <= OWN_D;
                        last_d  <= 1'b1;
                        m_valid <= 1'b1;
                        m_we    <= d_we;
                        m_addr  <= d_addr;
                        m_wdata <= d_wdata;
                        m_wstrb <= d_we ? d_wstrb : 4'b0000;
                        state   <= REQ;
                    end else if (grant_if) begin
                        owner   <= OWN_IF;
                        last_d  <= 1'b0;
                        m_valid <= 1'b1;
                        m_we    <= 1'b0;
                        m_addr  <= if_addr;
                        m_wdata <= '0;
                        m_wstrb <= 4'b0000;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    cnt <= cnt_inc;
                    if (!tmo && m_ready) begin
                        m_valid <= 1'b0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt_inc;
                    if (m_rvalid) begin
                        state <= IDLE;
                        if (owner == OWN_IF) begin
                            if_done  <= 1'b1;
                            if_rdata <= m_rdata;
                        end else begin
                            d_done <= 1'b1;
                            if (!m_we) begin
                                d_rdata <= m_rdata;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
            if (abort) begin
                state   <= IDLE;
                m_valid <= 1'b0;
                err     <= 1'b1;
                if (owner == OWN_IF) begin
                    if_done  <= 1'b1;
                    if_rdata <= '0;
                end else begin
                    d_done  <= 1'b1;
                    d_rdata <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: directed vector table, corner sequences and
// randomized traffic against a behavioural memory and requester model.
module tb_mem_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_done;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_done;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_wstrb;
    logic        m_valid, m_ready, m_we, m_rvalid;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_wstrb;
    logic        stall, err;

    logic        r_ready, r_rvalid, man_ready, man_rvalid;
    logic [31:0] r_rdata, man_rdata;
    bit          mem_on, rand_dly, chk_pay, grant_chk;
    int          rdly_fix, rsp_fix;
    int          n_cmp = 0;
    int          n_err = 0;

    logic [31:0] mem [logic [31:0]];
    logic        acc_we;
    logic [31:0] acc_addr, acc_wdata;
    logic [3:0]  acc_wstrb;

    assign m_ready  = mem_on ? r_ready : man_ready;
    assign m_rvalid = mem_on ? r_rvalid : man_rvalid;
    assign m_rdata  = mem_on ? r_rdata : man_rdata;

    always #5 clk = ~clk;

    mem_arb #(.TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr),
        .if_rdata(if_rdata), .if_done(if_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_rdata(d_rdata), .d_done(d_done),
        .m_valid(m_valid), .m_ready(m_ready), .m_we(m_we),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .stall(stall), .err(err)
    );

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return a ^ 32'hA5C3_5A3C;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : init_val(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Behavioural memory: one response per accepted request.
    initial begin
        logic [31:0] a, wd, cur;
        logic [3:0]  s;
        logic        w;
        int          d1, d2;
        r_ready = 1'b0; r_rvalid = 1'b0; r_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_on && m_valid) begin
                a = m_addr; w = m_we; wd = m_wdata; s = m_wstrb;
                d1 = rand_dly ? int'($urandom_range(0, 2)) : rdly_fix;
                d2 = rand_dly ? int'($urandom_range(0, 2)) : rsp_fix;
                for (int i = 0; i < d1; i++) begin
                    @(negedge clk);
                    chk("req_valid_hold", m_valid, 1'b1);
                    chk("req_addr_hold", m_addr, a);
                    chk("req_wstrb_hold", m_wstrb, s);
                    chk("req_wdata_hold", m_wdata, wd);
                end
                r_ready = 1'b1;
                acc_we = m_we; acc_addr = m_addr;
                acc_wdata = m_wdata; acc_wstrb = m_wstrb;
                if (chk_pay) begin
                    if (m_addr[13]) begin
                        chk("pay_d_we", m_we, d_we);
                        chk("pay_d_addr", m_addr, d_addr);
                        chk("pay_d_wstrb", m_wstrb, d_we ? d_wstrb : 4'b0);
                        if (d_we) chk("pay_d_wdata", m_wdata, d_wdata);
                    end else begin
                        chk("pay_if_we", m_we, 1'b0);
                        chk("pay_if_addr", m_addr, if_addr);
                        chk("pay_if_wstrb", m_wstrb, 4'b0);
                    end
                end
                @(negedge clk);
                r_ready = 1'b0;
                repeat (d2) @(negedge clk);
                if (w) begin
                    cur = mem_rd(a);
                    for (int b = 0; b < 4; b++)
                        if (s[b]) cur[8*b +: 8] = wd[8*b +: 8];
                    mem[a] = cur;
                    r_rdata = $urandom;
                end else begin
                    r_rdata = mem_rd(a);
                end
                r_rvalid = 1'b1;
                @(negedge clk);
                r_rvalid = 1'b0;
            end
        end
    end

    // Stall formula and no two back-to-back D grants while IF waits.
    initial begin
        logic mv_prev, ifp_prev, last_gd, own_d;
        mv_prev = 1'b0; ifp_prev = 1'b0; last_gd = 1'b0;
        forever begin
            @(negedge clk);
            if (rst)
                chk("stall", stall, (if_req & ~if_done) | (d_req & ~d_done));
            if (!grant_chk || !rst) begin
                last_gd = 1'b0;
            end else if (m_valid && !mv_prev) begin
                own_d = m_addr[13];
                if (last_gd && ifp_prev) chk("no_dd_grant", own_d, 1'b0);
                last_gd = own_d;
            end
            mv_prev  = m_valid;
            ifp_prev = if_req & ~if_done;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check_rst(input string p);
        chk({p, "_m_valid"}, m_valid, 1'b0);
        chk({p, "_m_we"}, m_we, 1'b0);
        chk({p, "_m_addr"}, m_addr, 32'h0);
        chk({p, "_m_wdata"}, m_wdata, 32'h0);
        chk({p, "_m_wstrb"}, m_wstrb, 4'h0);
        chk({p, "_if_done"}, if_done, 1'b0);
        chk({p, "_d_done"}, d_done, 1'b0);
        chk({p, "_if_rdata"}, if_rdata, 32'h0);
        chk({p, "_d_rdata"}, d_rdata, 32'h0);
        chk({p, "_err"}, err, 1'b0);
    endtask

    task automatic do_xact(input bit is_d, input bit we,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] strb, output int lat,
                           output logic [31:0] rd, output int mv);
        int sc;
        bit ok;
        @(posedge clk); #1;
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_addr = addr;
            d_wdata = wd; d_wstrb = strb;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        lat = -1; mv = 0; sc = 0; ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (m_valid) mv++;
            if (stall) sc++;
            if (is_d ? d_done : if_done) begin
                ok = 1'b1;
                break;
            end
        end
        chk("xact_done_seen", ok, 1'b1);
        rd = is_d ? d_rdata : if_rdata;
        chk("stall_cycles", sc, lat);
        @(posedge clk); #1;
        if (is_d) d_req = 1'b0; else if_req = 1'b0;
        @(negedge clk);
        chk("done_one_cycle", is_d ? d_done : if_done, 1'b0);
    endtask

    task automatic wait_any(input string name, output int lat);
        bit ok;
        ok = 1'b0; lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (if_done || d_done) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, ok, 1'b1);
    endtask

    task automatic if_proc(input int n);
        logic [31:0] a;
        int gap, lat;
        bit ok;
        for (int i = 0; i < n; i++) begin
            gap = int'($urandom_range(0, 3));
            @(posedge clk); #1;
            if (gap > 0) begin
                if_req = 1'b0;
                repeat (gap) @(posedge clk);
                #1;
            end
            a = 32'h1800 + ($urandom_range(0, 127) << 2);
            if_req = 1'b1; if_addr = a;
            ok = 1'b0; lat = -1;
            for (int c = 0; c < 60; c++) begin
                @(negedge clk);
                lat++;
                if (if_done) begin
                    ok = 1'b1;
                    break;
                end
            end
            chk("if_rand_done", ok, 1'b1);
            chk("if_rand_minlat", lat >= 3, 1'b1);
            chk("if_rand_rdata", if_rdata, init_val(a));
        end
        @(posedge clk); #1;
        if_req = 1'b0;
    endtask

    task automatic d_proc(input int n);
        logic [31:0] dm [logic [31:0]];
        logic [31:0] a, wd, cur, last, exp;
        logic [3:0]  s;
        bit          w, ok;
        int          gap, lat;
        last = '0;
        for (int i = 0; i < n; i++) begin
            gap = int'($urandom_range(0, 3));
            @(posedge clk); #1;
            if (gap > 0) begin
                d_req = 1'b0;
                repeat (gap) @(posedge clk);
                #1;
            end
            a  = 32'h2800 + ($urandom_range(0, 31) << 2);
            w  = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            wd = $urandom;
            s  = 4'($urandom_range(0, 15));
            d_req = 1'b1; d_we = w; d_addr = a; d_wdata = wd; d_wstrb = s;
            ok = 1'b0; lat = -1;
            for (int c = 0; c < 60; c++) begin
                @(negedge clk);
                lat++;
                if (d_done) begin
                    ok = 1'b1;
                    break;
                end
            end
            chk("d_rand_done", ok, 1'b1);
            chk("d_rand_minlat", lat >= 3, 1'b1);
            cur = dm.exists(a) ? dm[a] : init_val(a);
            if (w) begin
                for (int b = 0; b < 4; b++)
                    if (s[b]) cur[8*b +: 8] = wd[8*b +: 8];
                dm[a] = cur;
                exp = last;
            end else begin
                exp  = cur;
                last = cur;
            end
            chk("d_rand_rdata", d_rdata, exp);
        end
        @(posedge clk); #1;
        d_req = 1'b0;
    endtask

    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        bit          pre;
        logic [31:0] pre_val;
        int          rdly;
        int          rsp;
        logic [31:0] exp_rd;
        int          exp_lat;
        logic        exp_we;
        logic [3:0]  exp_wstrb;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int          lat, mv;
        logic [31:0] rd;

        tbl[0] = '{0, 0, 32'h100, 32'h0, 4'h0, 1, 32'h00000013,
                   0, 0, 32'h00000013, 3, 1'b0, 4'h0};
        tbl[1] = '{1, 0, 32'h2000, 32'h0, 4'h0, 1, 32'h12345678,
                   0, 0, 32'h12345678, 3, 1'b0, 4'h0};
        tbl[2] = '{1, 1, 32'h40, 32'hDEADBEEF, 4'b0011, 1, 32'h11223344,
                   5, 0, 32'h12345678, 8, 1'b1, 4'b0011};
        tbl[3] = '{1, 0, 32'h40, 32'h0, 4'hF, 0, 32'h0,
                   1, 2, 32'h1122BEEF, 6, 1'b0, 4'h0};
        tbl[4] = '{0, 0, 32'h104, 32'h0, 4'h0, 1, 32'hCAFEF00D,
                   2, 1, 32'hCAFEF00D, 6, 1'b0, 4'h0};
        tbl[5] = '{1, 1, 32'h44, 32'h0BADF00D, 4'hF, 0, 32'h0,
                   0, 0, 32'h1122BEEF, 3, 1'b1, 4'hF};
        tbl[6] = '{1, 0, 32'h44, 32'h0, 4'h0, 0, 32'h0,
                   0, 1, 32'h0BADF00D, 4, 1'b0, 4'h0};
        tbl[7] = '{0, 0, 32'h108, 32'h0, 4'h0, 1, 32'h00C0FFEE,
                   3, 3, 32'h00C0FFEE, 9, 1'b0, 4'h0};

        rst = 1'b0;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
        man_ready = 1'b0; man_rvalid = 1'b0; man_rdata = '0;
        mem_on = 1'b1; rand_dly = 1'b0; chk_pay = 1'b0; grant_chk = 1'b0;
        rdly_fix = 0; rsp_fix = 0;

        repeat (3) @(negedge clk);
        check_rst("rst");
        chk("rst_stall", stall, 1'b0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_m_valid", m_valid, 1'b0);

        for (int i = 0; i < 8; i++) begin
            if (tbl[i].pre) mem[tbl[i].addr] = tbl[i].pre_val;
            rdly_fix = tbl[i].rdly;
            rsp_fix  = tbl[i].rsp;
            do_xact(tbl[i].is_d, tbl[i].we, tbl[i].addr, tbl[i].wdata,
                    tbl[i].strb, lat, rd, mv);
            chk($sformatf("vec%0d_lat", i), lat, tbl[i].exp_lat);
            chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
            chk($sformatf("vec%0d_m_addr", i), acc_addr, tbl[i].addr);
            chk($sformatf("vec%0d_m_we", i), acc_we, tbl[i].exp_we);
            chk($sformatf("vec%0d_m_wstrb", i), acc_wstrb, tbl[i].exp_wstrb);
            if (tbl[i].we)
                chk($sformatf("vec%0d_m_wdata", i), acc_wdata, tbl[i].wdata);
        end
        chk("vec_store_mem", mem_rd(32'h40), 32'h1122BEEF);

        // Simultaneous requests, D keeps re-requesting
        rdly_fix = 0; rsp_fix = 0; grant_chk = 1'b1;
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h1000;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000; d_wstrb = 4'h0;
        wait_any("arb1_done_seen", lat);
        chk("arb1_d_first", d_done, 1'b1);
        chk("arb1_if_not", if_done, 1'b0);
        chk("arb1_lat", lat, 3);
        chk("arb1_rdata", d_rdata, mem_rd(32'h2000));
        @(posedge clk); #1;
        d_addr = 32'h2004;
        wait_any("arb2_done_seen", lat);
        chk("arb2_if_next", if_done, 1'b1);
        chk("arb2_d_not", d_done, 1'b0);
        chk("arb2_lat", lat, 3);
        chk("arb2_rdata", if_rdata, mem_rd(32'h1000));
        @(posedge clk); #1;
        if_req = 1'b0;
        wait_any("arb3_done_seen", lat);
        chk("arb3_d", d_done, 1'b1);
        chk("arb3_lat", lat, 3);
        chk("arb3_rdata", d_rdata, mem_rd(32'h2004));
        @(posedge clk); #1;
        d_req = 1'b0;
        grant_chk = 1'b0;

        // Memory never ready: timeout abort
        mem_on = 1'b0;
        do_xact(1, 0, 32'h2100, 32'h0, 4'h0, lat, rd, mv);
        chk("tmo_lat", lat, 9);
        chk("tmo_valid_cycles", mv, 8);
        chk("tmo_rdata", rd, 32'h0);
        chk("tmo_err", err, 1'b1);
        repeat (5) @(negedge clk);
        chk("tmo_err_sticky", err, 1'b1);
        mem_on = 1'b1;
        do_xact(0, 0, 32'h100, 32'h0, 4'h0, lat, rd, mv);
        chk("post_tmo_lat", lat, 3);
        chk("post_tmo_rdata", rd, 32'h00000013);
        chk("post_tmo_err", err, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_rst("tmo_rst");
        rst = 1'b1;

        // Reset while waiting for the response, then a stale response
        mem_on = 1'b0;
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h200;
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (m_valid) begin
                    seen = 1'b1;
                    break;
                end
            end
            chk("wrst_valid_seen", seen, 1'b1);
        end
        man_ready = 1'b1;
        @(negedge clk);
        man_ready = 1'b0;
        chk("wrst_in_wait", m_valid, 1'b0);
        rst = 1'b0;
        if_req = 1'b0;
        @(negedge clk);
        check_rst("wrst");
        rst = 1'b1;
        @(negedge clk);
        man_rvalid = 1'b1; man_rdata = 32'hBAD0BAD0;
        @(negedge clk);
        man_rvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("stale_if_done", if_done, 1'b0);
            chk("stale_d_done", d_done, 1'b0);
            chk("stale_if_rdata", if_rdata, 32'h0);
            chk("stale_m_valid", m_valid, 1'b0);
            @(negedge clk);
        end
        mem_on = 1'b1;
        do_xact(0, 0, 32'h300, 32'h0, 4'h0, lat, rd, mv);
        chk("after_rst_lat", lat, 3);
        chk("after_rst_rdata", rd, init_val(32'h300));

        // Randomized concurrent traffic
        rand_dly = 1'b1; chk_pay = 1'b1; grant_chk = 1'b1;
        fork
            if_proc(40);
            d_proc(40);
        join
        repeat (4) @(negedge clk);
        chk("rand_no_err", err, 1'b0);
        chk("rand_idle", m_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL be the maximum cycles a granted transaction may spend in REQ+WAIT before abort.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 if_req  input  1  fetch request, held high with if_addr stable until if_done.
REQ-005 if_addr  input  32  fetch byte address.
REQ-006 if_rdata  output  32  fetched instruction word, registered.
REQ-007 if_done  output  1  one-cycle fetch completion pulse.
REQ-008 d_req  input  1  data request, held high with payload stable until d_done.
REQ-009 d_we  input  1  1 = store, 0 = load.
REQ-010 d_addr  input  32  data byte address.
REQ-011 d_wdata  input  32  store data.
REQ-012 d_wstrb  input  4  store byte enables.
REQ-013 d_rdata  output  32  load data, registered.
REQ-014 d_done  output  1  one-cycle data completion pulse.
REQ-015 m_valid  output  1  memory request valid.
REQ-016 m_ready  input  1  memory accepts request.
REQ-017 m_we, m_addr, m_wdata, m_wstrb  output  1/32/32/4  memory request payload.
REQ-018 m_rvalid  input  1  memory response, one per accepted request, reads and writes alike.
REQ-019 m_rdata  input  32  response data.
REQ-020 stall  output  1  core stall.
REQ-021 err  output  1  sticky timeout flag.

Function
REQ-022 The FSM SHALL have states IDLE, REQ, WAIT, plus an owner register (IF or D).
REQ-023 IDLE: requests SHALL be sampled only here; on grant, payload SHALL be latched and the FSM SHALL enter REQ, so m_valid rises one cycle after the grant cycle.
REQ-024 Arbitration: fixed priority D over IF, except after a D grant with if_req pending, the next grant SHALL go to IF (no two consecutive D grants while IF waits).
REQ-025 Fetch transactions SHALL drive m_we=0 and m_wstrb=4'b0000; data loads m_wstrb=4'b0000; stores m_wstrb=d_wstrb.
REQ-026 REQ: m_valid=1 with payload constant until m_valid&&m_ready, then WAIT; m_rvalid in REQ SHALL be ignored.
REQ-027 WAIT: m_valid=0; on m_rvalid, owner's done SHALL pulse the next cycle for exactly one cycle, the FSM SHALL return to IDLE; for loads/fetches m_rdata SHALL be captured into owner's rdata; stores SHALL leave d_rdata unchanged.
REQ-028 if_rdata/d_rdata SHALL hold their value until the next completion for that owner.
REQ-029 Minimum latency request-to-done with m_ready=1 and zero-wait response: 3 cycles (grant, REQ, WAIT+rvalid, done following).
REQ-030 stall = (if_req & ~if_done) | (d_req & ~d_done), combinational.
REQ-031 An 8-bit-or-wider counter SHALL count cycles in REQ/WAIT, cleared on IDLE; at count == TIMEOUT the FSM SHALL abort to IDLE, pulse owner done with rdata 32'h0, and set err until reset.
REQ-032 A requester dropping req mid-transaction SHALL NOT abort it; the transaction completes and done pulses.
REQ-033 m_rvalid in IDLE (stale response) SHALL be ignored.
REQ-034 The done pulse cycle and next IDLE sampling SHALL not overlap: a requester re-asserting immediately is granted no earlier than the cycle after done.

Reset
REQ-035 While rst=0: state IDLE, owner IF, m_valid=0, m_we=0, m_addr/m_wdata=0, m_wstrb=0, if_done=d_done=0, if_rdata=d_rdata=0, counter=0, err=0, consecutive-D flag clear.
REQ-036 Reset asserted mid-transaction SHALL discard it without any done pulse; responses after release SHALL be ignored per REQ-033.

Verification
REQ-037 if_req, if_addr=0x100, m_ready=1, m_rvalid one cycle after accept with 0x00000013 -> m_addr=0x100, if_rdata=0x00000013, if_done pulse at cycle 3, stall high cycles 0-2.
REQ-038 if_req and d_req (load 0x2000) same cycle, both held -> D granted first, then IF; repeated d_req with if_req pending never yields two back-to-back D grants.
REQ-039 Store d_addr=0x40, d_wdata=0xDEADBEEF, d_wstrb=4'b0011, m_ready low 5 cycles -> payload stable during REQ, m_wstrb=4'b0011, d_done after rvalid, d_rdata unchanged.
REQ-040 TIMEOUT=8, m_ready never asserted -> abort after 8 cycles, d_done pulse, d_rdata=0, err=1 held until rst.
REQ-041 rst pulsed low during WAIT, then m_rvalid -> no done, all outputs at reset values, next request completes normally.
